// File: rtl/btb_update_unit.sv
// btb_update_unit
//   Write-side companion of the fetch-stage BTB. Compares each branch resolved
//   in MEM against the prediction carried down from fetch. On a mismatch it
//   pulses mispredict with the correct fetch PC and opens a squash window in
//   which wrong-path resolutions are dropped. Allocate/update requests for the
//   BTB are queued and drained through a valid/ready write port.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   res_valid/pc/taken/target       resolved branch from MEM
//   pred_hit/taken/target           prediction made at fetch
//   stall_out                       queue full, MEM must hold the resolution
//   mispredict, redirect_pc         registered flush pulse and correct PC
//   btb_wr_valid/ready              write-port handshake
//   btb_wr_pc/target/taken/alloc    head update request
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_RUN     | resolutions accepted, compared and queued
// ST_SQUASH  | wrong-path window, res_valid ignored, queue still drains

module btb_update_unit #(
  parameter int QDEPTH     = 4,
  parameter int SQUASH_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic        res_taken,
  input  logic [15:0] res_target,
  input  logic        pred_hit,
  input  logic        pred_taken,
  input  logic [15:0] pred_target,
  output logic        stall_out,
  output logic        mispredict,
  output logic [15:0] redirect_pc,
  output logic        btb_wr_valid,
  input  logic        btb_wr_ready,
  output logic [15:0] btb_wr_pc,
  output logic [15:0] btb_wr_target,
  output logic        btb_wr_taken,
  output logic        btb_wr_alloc
);

  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int SCW = (SQUASH_CYC > 1) ? $clog2(SQUASH_CYC + 1) : 1;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  logic [0:0]     state;
  logic [SCW-1:0] sq_cnt;

  logic [15:0] q_pc     [QDEPTH];
  logic [15:0] q_target [QDEPTH];
  logic        q_taken  [QDEPTH];
  logic        q_alloc  [QDEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_last;
  logic [CW-1:0] count;

  logic        run;
  logic        full;
  logic        accept;
  logic        eff_taken;
  logic        mp;
  logic        want_enq;
  logic        coalesce;
  logic        push;
  logic        pop;
  logic [15:0] new_target;
  logic        new_alloc;

  assign run       = (state == ST_RUN);
  assign full      = (count == CW'(QDEPTH));
  assign stall_out = full & run;
  assign accept    = res_valid & run & ~full;

  assign eff_taken = pred_hit & pred_taken;
  assign mp        = (eff_taken != res_taken) |
                     (eff_taken & res_taken & (pred_target != res_target));

  // Not-taken misses carry nothing worth storing.
  assign want_enq   = accept & (res_taken | pred_hit);
  assign tail_last  = tail - PW'(1);
  // The head may be mid-handshake, so only fold into the tail when it is
  // a different entry from the head.
  assign coalesce   = want_enq & (count >= CW'(2)) & (q_pc[tail_last] == res_pc);
  assign push       = want_enq & ~coalesce;
  assign pop        = btb_wr_valid & btb_wr_ready;
  assign new_target = res_taken ? res_target : pred_target;
  assign new_alloc  = ~pred_hit;

  // Head fields are gated so every output reads 0 while the queue is empty
  // or held in reset; the storage itself needs no reset.
  assign btb_wr_valid  = (count != '0);
  assign btb_wr_pc     = btb_wr_valid ? q_pc[head]     : 16'h0000;
  assign btb_wr_target = btb_wr_valid ? q_target[head] : 16'h0000;
  assign btb_wr_taken  = btb_wr_valid & q_taken[head];
  assign btb_wr_alloc  = btb_wr_valid & q_alloc[head];

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]     <= res_pc;
      q_target[tail] <= new_target;
      q_taken[tail]  <= res_taken;
      q_alloc[tail]  <= new_alloc;
    end else if (coalesce) begin
      q_target[tail_last] <= new_target;
      q_taken[tail_last]  <= res_taken;
      q_alloc[tail_last]  <= q_alloc[tail_last] | new_alloc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= 16'h0000;
    end else begin
      mispredict <= accept & mp;
      if (accept & mp)
        redirect_pc <= res_taken ? res_target : res_pc + 16'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      sq_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept & mp) begin
            state  <= ST_SQUASH;
            sq_cnt <= SCW'(SQUASH_CYC);
          end
        end
        default: begin
          // <= 1 also covers a zero-length window so SQUASH never sticks.
          if (sq_cnt <= SCW'(1)) begin
            state  <= ST_RUN;
            sq_cnt <= '0;
          end else begin
            sq_cnt <= sq_cnt - SCW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_unit.sv
module tb_btb_update_unit;

  localparam int QDEPTH     = 4;
  localparam int SQUASH_CYC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic [15:0] res_pc;
  logic        res_taken;
  logic [15:0] res_target;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        stall_out;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic        btb_wr_valid;
  logic        btb_wr_ready;
  logic [15:0] btb_wr_pc;
  logic [15:0] btb_wr_target;
  logic        btb_wr_taken;
  logic        btb_wr_alloc;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] target;
    logic        taken;
    logic        alloc;
  } ent_t;

  btb_update_unit #(.QDEPTH(QDEPTH), .SQUASH_CYC(SQUASH_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .stall_out(stall_out),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .btb_wr_valid(btb_wr_valid), .btb_wr_ready(btb_wr_ready),
    .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
    .btb_wr_taken(btb_wr_taken), .btb_wr_alloc(btb_wr_alloc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic v, input logic [15:0] pc, input logic tk,
                         input logic [15:0] tgt, input logic hit,
                         input logic ptk, input logic [15:0] ptgt);
    res_valid   = v;
    res_pc      = pc;
    res_taken   = tk;
    res_target  = tgt;
    pred_hit    = hit;
    pred_taken  = ptk;
    pred_target = ptgt;
  endtask

  task automatic clear_res();
    set_res(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_res();
    btb_wr_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_res();
    btb_wr_ready = 1'b0;
    tick();
    total_cnt++;
    if ({btb_wr_valid, stall_out, mispredict, redirect_pc} !== 19'd0)
      $display("FAIL reset_initial got valid=%b stall=%b mp=%b redir=%h exp all 0",
               btb_wr_valid, stall_out, mispredict, redirect_pc);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // build up traffic, the last one mispredicting
    set_res(1'b1, 16'h1100, 1'b1, 16'h2000, 1'b1, 1'b1, 16'h2000); tick();
    set_res(1'b1, 16'h1104, 1'b1, 16'h2004, 1'b1, 1'b1, 16'h2004); tick();
    set_res(1'b1, 16'h1108, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000); tick();
    clear_res();
    total_cnt++;
    if (btb_wr_valid !== 1'b1 || mispredict !== 1'b1 || redirect_pc !== 16'h2222)
      $display("FAIL reset_pretraffic got valid=%b mp=%b redir=%h exp 1 1 2222",
               btb_wr_valid, mispredict, redirect_pc);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, btb_wr_alloc,
         stall_out, mispredict, redirect_pc} !== 54'd0)
      $display("FAIL reset_async got valid=%b pc=%h tgt=%h mp=%b redir=%h exp all 0",
               btb_wr_valid, btb_wr_pc, btb_wr_target, mispredict, redirect_pc);
    else pass_cnt++;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    btb_wr_ready = 1'b1;
    tick();
    total_cnt++;
    if (btb_wr_valid !== 1'b0 || stall_out !== 1'b0 || mispredict !== 1'b0)
      $display("FAIL reset_release got valid=%b stall=%b mp=%b exp 0 0 0",
               btb_wr_valid, stall_out, mispredict);
    else pass_cnt++;
  endtask

  task automatic test_correct_hit();
    btb_wr_ready = 1'b1;
    set_res(1'b1, 16'h1000, 1'b1, 16'h3000, 1'b1, 1'b1, 16'h3000);
    tick();
    clear_res();
    total_cnt++;
    if (mispredict !== 1'b0)
      $display("FAIL hit_mispredict got %b exp 0", mispredict);
    else pass_cnt++;
    total_cnt++;
    if ({btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, btb_wr_alloc} !==
        {1'b1, 16'h1000, 16'h3000, 1'b1, 1'b0})
      $display("FAIL hit_write got v=%b pc=%h tgt=%h tk=%b al=%b exp 1 1000 3000 1 0",
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, btb_wr_alloc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (btb_wr_valid !== 1'b0)
      $display("FAIL hit_drained got valid=%b exp 0", btb_wr_valid);
    else pass_cnt++;
  endtask

  task automatic test_taken_miss();
    btb_wr_ready = 1'b1;
    set_res(1'b1, 16'h1010, 1'b1, 16'h2040, 1'b0, 1'b0, 16'h0000);
    tick();
    total_cnt++;
    if (mispredict !== 1'b1 || redirect_pc !== 16'h2040)
      $display("FAIL miss_redirect got mp=%b redir=%h exp 1 2040", mispredict, redirect_pc);
    else pass_cnt++;
    total_cnt++;
    if ({btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, btb_wr_alloc} !==
        {1'b1, 16'h1010, 16'h2040, 1'b1, 1'b1})
      $display("FAIL miss_write got v=%b pc=%h tgt=%h tk=%b al=%b exp 1 1010 2040 1 1",
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, btb_wr_alloc);
    else pass_cnt++;
    // wrong-path resolutions that would otherwise mispredict and enqueue
    for (int i = 0; i < SQUASH_CYC; i++) begin
      set_res(1'b1, 16'h1A00 + 16'(i * 4), 1'b1, 16'h5000, 1'b0, 1'b0, 16'h0000);
      tick();
      total_cnt++;
      if (btb_wr_valid !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 16'h2040)
        $display("FAIL squash_drop%0d got v=%b mp=%b redir=%h exp 0 0 2040",
                 i, btb_wr_valid, mispredict, redirect_pc);
      else pass_cnt++;
    end
    set_res(1'b1, 16'h1AA0, 1'b1, 16'h1B00, 1'b1, 1'b1, 16'h1B00);
    tick();
    clear_res();
    total_cnt++;
    if (btb_wr_valid !== 1'b1 || btb_wr_pc !== 16'h1AA0 || mispredict !== 1'b0)
      $display("FAIL squash_end got v=%b pc=%h mp=%b exp 1 1aa0 0",
               btb_wr_valid, btb_wr_pc, mispredict);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_nt_mispredict();
    btb_wr_ready = 1'b1;
    set_res(1'b1, 16'h1020, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1200);
    tick();
    clear_res();
    total_cnt++;
    if (mispredict !== 1'b1 || redirect_pc !== 16'h1022)
      $display("FAIL nt_redirect got mp=%b redir=%h exp 1 1022", mispredict, redirect_pc);
    else pass_cnt++;
    total_cnt++;
    if ({btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, btb_wr_alloc} !==
        {1'b1, 16'h1020, 16'h1200, 1'b0, 1'b0})
      $display("FAIL nt_write got v=%b pc=%h tgt=%h tk=%b al=%b exp 1 1020 1200 0 0",
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, btb_wr_alloc);
    else pass_cnt++;
    for (int i = 0; i < SQUASH_CYC + 1; i++) tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    logic [15:0] exp_pc [5];
    exp_pc = '{16'h1100, 16'h1104, 16'h1108, 16'h110C, 16'h1110};
    btb_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_res(1'b1, exp_pc[i], 1'b1, 16'h2100 + 16'(i), 1'b1, 1'b1, 16'h2100 + 16'(i));
      tick();
    end
    set_res(1'b1, 16'h1110, 1'b1, 16'h2104, 1'b1, 1'b1, 16'h2104);
    total_cnt++;
    if (stall_out !== 1'b1)
      $display("FAIL bp_full_stall got %b exp 1", stall_out);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (stall_out !== 1'b1 || btb_wr_pc !== 16'h1100)
      $display("FAIL bp_hold got stall=%b head=%h exp 1 1100", stall_out, btb_wr_pc);
    else pass_cnt++;
    btb_wr_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      logic acc;
      acc = res_valid && !stall_out;
      if (btb_wr_valid) got.push_back(btb_wr_pc);
      tick();
      if (acc) clear_res();
      if (!btb_wr_valid && !res_valid) break;
    end
    total_cnt++;
    if (got.size() != 5)
      $display("FAIL bp_count got %0d writes exp 5", got.size());
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        total_cnt++;
        if (got[i] !== exp_pc[i])
          $display("FAIL bp_order%0d got %h exp %h", i, got[i], exp_pc[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_coalesce();
    logic [15:0] gpc[$];
    logic [15:0] gtg[$];
    btb_wr_ready = 1'b0;
    set_res(1'b1, 16'h1100, 1'b1, 16'h2000, 1'b1, 1'b1, 16'h2000); tick();
    set_res(1'b1, 16'h1104, 1'b1, 16'h2004, 1'b1, 1'b1, 16'h2004); tick();
    set_res(1'b1, 16'h1104, 1'b1, 16'h4000, 1'b1, 1'b1, 16'h4000); tick();
    clear_res();
    total_cnt++;
    if (stall_out !== 1'b0 || mispredict !== 1'b0)
      $display("FAIL co_nostall got stall=%b mp=%b exp 0 0", stall_out, mispredict);
    else pass_cnt++;
    btb_wr_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (!btb_wr_valid) break;
      gpc.push_back(btb_wr_pc);
      gtg.push_back(btb_wr_target);
      tick();
    end
    total_cnt++;
    if (gpc.size() != 2)
      $display("FAIL co_count got %0d writes exp 2", gpc.size());
    else pass_cnt++;
    if (gpc.size() >= 2) begin
      total_cnt++;
      if (gpc[0] !== 16'h1100 || gtg[0] !== 16'h2000)
        $display("FAIL co_first got %h/%h exp 1100/2000", gpc[0], gtg[0]);
      else pass_cnt++;
      total_cnt++;
      if (gpc[1] !== 16'h1104 || gtg[1] !== 16'h4000)
        $display("FAIL co_second got %h/%h exp 1104/4000", gpc[1], gtg[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    ent_t        mq[$];
    int          sq_left;
    logic        m_mp;
    logic [15:0] m_redir;
    logic [15:0] pcs  [4];
    logic [15:0] tgts [3];
    int          errs;
    pcs  = '{16'h1100, 16'h1104, 16'h1108, 16'h110C};
    tgts = '{16'h2000, 16'h2002, 16'h3000};
    errs = 0;
    do_reset();
    sq_left = 0;
    m_mp    = 1'b0;
    m_redir = 16'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic exp_stall, acc, eff, mpn, deq;
      exp_stall = (mq.size() == QDEPTH) && (sq_left == 0);
      total_cnt++;
      if (stall_out !== exp_stall || btb_wr_valid !== (mq.size() != 0) ||
          mispredict !== m_mp || redirect_pc !== m_redir) begin
        if (errs < 20)
          $display("FAIL rnd_ctrl cyc%0d got st=%b v=%b mp=%b rd=%h exp %b %b %b %h",
                   cyc, stall_out, btb_wr_valid, mispredict, redirect_pc,
                   exp_stall, mq.size() != 0, m_mp, m_redir);
        errs++;
      end else pass_cnt++;
      if (mq.size() != 0) begin
        total_cnt++;
        if (btb_wr_pc !== mq[0].pc || btb_wr_target !== mq[0].target ||
            btb_wr_taken !== mq[0].taken || btb_wr_alloc !== mq[0].alloc) begin
          if (errs < 20)
            $display("FAIL rnd_head cyc%0d got %h %h %b %b exp %h %h %b %b", cyc,
                     btb_wr_pc, btb_wr_target, btb_wr_taken, btb_wr_alloc,
                     mq[0].pc, mq[0].target, mq[0].taken, mq[0].alloc);
          errs++;
        end else pass_cnt++;
      end
      if (!(res_valid && exp_stall)) begin
        res_valid   = ($urandom_range(0, 9) < 7);
        res_pc      = pcs[$urandom_range(0, 3)];
        res_taken   = $urandom_range(0, 1) == 1;
        res_target  = tgts[$urandom_range(0, 2)];
        pred_hit    = $urandom_range(0, 1) == 1;
        pred_taken  = $urandom_range(0, 1) == 1;
        pred_target = tgts[$urandom_range(0, 2)];
      end
      btb_wr_ready = $urandom_range(0, 1) == 1;

      acc = res_valid && (sq_left == 0) && (mq.size() < QDEPTH);
      eff = pred_hit && pred_taken;
      mpn = (eff != res_taken) || (eff && res_taken && pred_target != res_target);
      deq = (mq.size() != 0) && btb_wr_ready;
      begin
        ent_t        e;
        logic        do_enq;
        logic [15:0] r_pc;
        e.pc     = res_pc;
        e.target = res_taken ? res_target : pred_target;
        e.taken  = res_taken;
        e.alloc  = !pred_hit;
        do_enq   = acc && (res_taken || pred_hit);
        r_pc     = res_taken ? res_target : res_pc + 16'd2;
        tick();
        m_mp = acc && mpn;
        if (m_mp) begin
          m_redir = r_pc;
          sq_left = SQUASH_CYC;
        end else if (sq_left > 0) begin
          sq_left--;
        end
        if (do_enq) begin
          if (mq.size() >= 2 && mq[mq.size()-1].pc == e.pc) begin
            mq[mq.size()-1].target = e.target;
            mq[mq.size()-1].taken  = e.taken;
            mq[mq.size()-1].alloc  = mq[mq.size()-1].alloc | e.alloc;
          end else begin
            mq.push_back(e);
          end
        end
        if (deq) void'(mq.pop_front());
      end
    end
    clear_res();
    btb_wr_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_res();
    btb_wr_ready = 1'b0;
    test_reset();
    test_correct_hit();
    test_taken_miss();
    test_nt_mispredict();
    test_backpressure();
    test_coalesce();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
